// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared types and constants for the bit-serial subtractor.
// Contents: FSM state enum, default operand width, bit-counter width helper.
// No ports; imported by the interface, the cell and the top.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SERSUB_DEFAULT_WIDTH = 8;

    // Bit-counter width: enough to count 0 .. width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result bus.
// master drives start, a, b; slave (the subtractor) drives busy, done, diff,
// borrow_out and, when SERSUB_OVF_EN is defined, ovf.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SERSUB_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
`ifdef SERSUB_OVF_EN
        input  ovf,
`endif
        input  borrow_out
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
`ifdef SERSUB_OVF_EN
        output ovf,
`endif
        output borrow_out
    );

endinterface

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: one-bit combinational full subtractor, d = x - y - bin.
// Ports: x (minuend bit), y (subtrahend bit), bin (borrow in),
// d (difference bit), bo (borrow out).
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    // Borrow when y exceeds x, or when x == y and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor cell.
// Ports: clk, rst (sync, active-high), bus (slave modport: start/a/b in; busy/done/
// diff/borrow_out out, plus ovf when SERSUB_OVF_EN is defined). Latency WIDTH edges.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d;
    logic             bo;
`ifdef SERSUB_OVF_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (brw),
        .d   (d),
        .bo  (bo)
    );

    // Result fills from the top so the first (LSB) bit ends up at bit 0.
    assign res_next = {d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        cnt    <= '0;
                        brw    <= 1'b0;
                        busy_q <= 1'b1;
`ifdef SERSUB_OVF_EN
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    brw    <= bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Last bit is folded in on the same edge that publishes the result.
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= res_next;
                        borrow_q <= bo;
`ifdef SERSUB_OVF_EN
                        ovf_q    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
`ifdef SERSUB_OVF_EN
    assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH 8, 2 and 4.
// Covers reset state, latency/busy framing, borrow, overflow (with SERSUB_OVF_EN),
// held start, mid-operation reset and exhaustive small-width results.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(2)) if2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation: start at edge k, expect done exactly 8 edges later.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_bo);
        int lat;
        int bcnt;
        if8.a     = a;
        if8.b     = b;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!if8.done && lat < 20) begin
            if (if8.busy) bcnt++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " busy cycles"}, bcnt, 8);
        chk({tag, " diff"}, {24'd0, if8.diff}, {24'd0, exp_d});
        chk({tag, " borrow"}, {31'd0, if8.borrow_out}, {31'd0, exp_bo});
        chk({tag, " busy at done"}, {31'd0, if8.busy}, 0);
        tick();
        chk({tag, " done one cycle"}, {31'd0, if8.done}, 0);
    endtask

    initial begin
        int nd;
        int t1;
        int t2;
        int lat;
        logic [7:0] d1;
        logic [7:0] d2;
        logic seen;
        logic [2:0] exp2;
        logic [4:0] exp4;

        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;
        tick();
        tick();
        chk("reset busy", {31'd0, if8.busy}, 0);
        chk("reset done", {31'd0, if8.done}, 0);
        chk("reset diff", {24'd0, if8.diff}, 0);
        chk("reset borrow", {31'd0, if8.borrow_out}, 0);
`ifdef SERSUB_OVF_EN
        chk("reset ovf", {31'd0, if8.ovf}, 0);
`endif
        rst = 1'b0;
        tick();

        run8("05-03", 8'h05, 8'h03, 8'h02, 1'b0);
        run8("03-05", 8'h03, 8'h05, 8'hFE, 1'b1);
        run8("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1);

        // Results hold while idle even as the operand inputs move.
        if8.a = 8'hAA;
        if8.b = 8'h55;
        repeat (3) tick();
        chk("hold diff", {24'd0, if8.diff}, 32'h01);
        chk("hold borrow", {31'd0, if8.borrow_out}, 1);

        run8("80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERSUB_OVF_EN
        chk("80-01 ovf", {31'd0, if8.ovf}, 1);
`endif
        run8("7F-01", 8'h7F, 8'h01, 8'h7E, 1'b0);
`ifdef SERSUB_OVF_EN
        chk("7F-01 ovf", {31'd0, if8.ovf}, 0);
`endif
        run8("5A-5A", 8'h5A, 8'h5A, 8'h00, 1'b0);

        // start held high; operands change during the first SHIFT.
        if8.a     = 8'h10;
        if8.b     = 8'h01;
        if8.start = 1'b1;
        tick();
        nd = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                if8.a = 8'hFF;
                if8.b = 8'h00;
            end
            tick();
            if (if8.done) begin
                if (nd == 0) begin t1 = i; d1 = if8.diff; end
                else if (nd == 1) begin t2 = i; d2 = if8.diff; end
                nd++;
            end
        end
        if8.start = 1'b0;
        chk("held start done count", nd, 2);
        chk("held start first done edge", t1, 8);
        chk("held start second done edge", t2, 18);
        chk("held start first diff", {24'd0, d1}, 32'h0F);
        chk("held start second diff", {24'd0, d2}, 32'hFF);
        repeat (12) tick();

        // Reset sampled at the end of SHIFT cycle 4 aborts the operation.
        if8.a     = 8'h05;
        if8.b     = 8'h03;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", {31'd0, if8.busy}, 0);
        chk("abort done", {31'd0, if8.done}, 0);
        chk("abort diff", {24'd0, if8.diff}, 0);
        chk("abort borrow", {31'd0, if8.borrow_out}, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (if8.done) seen = 1'b1;
        end
        chk("abort no done", {31'd0, seen}, 0);
        run8("after abort 05-03", 8'h05, 8'h03, 8'h02, 1'b0);

        // Exhaustive WIDTH=2.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                if2.a     = x[1:0];
                if2.b     = y[1:0];
                if2.start = 1'b1;
                tick();
                if2.start = 1'b0;
                lat = 0;
                while (!if2.done && lat < 10) begin
                    tick();
                    lat++;
                end
                exp2 = {1'b0, x[1:0]} - {1'b0, y[1:0]};
                chk($sformatf("w2 done %0d-%0d", x, y), {31'd0, if2.done}, 1);
                chk($sformatf("w2 %0d-%0d", x, y), {29'd0, if2.borrow_out, if2.diff}, {29'd0, exp2});
                tick();
            end
        end

        // Exhaustive WIDTH=4.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                if4.a     = x[3:0];
                if4.b     = y[3:0];
                if4.start = 1'b1;
                tick();
                if4.start = 1'b0;
                lat = 0;
                while (!if4.done && lat < 12) begin
                    tick();
                    lat++;
                end
                exp4 = {1'b0, x[3:0]} - {1'b0, y[3:0]};
                chk($sformatf("w4 latency %0d-%0d", x, y), lat, 4);
                chk($sformatf("w4 %0d-%0d", x, y), {27'd0, if4.borrow_out, if4.diff}, {27'd0, exp4});
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial unsigned subtractor computing `diff = a - b` over `WIDTH` bits. It processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. A start/busy/done handshake frames each operation. It is the sequential, multi-bit successor to the combinational half subtractor in the arithmetic library, for area-constrained datapaths that can tolerate `WIDTH`-cycle latency.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range ≥ 2.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  operation request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled with `start`.
- `b`  input  WIDTH  subtrahend; sampled with `start`.
- `busy`  output  1  high while bits are being processed (SHIFT state).
- `done`  output  1  one-cycle pulse; results valid.
- `diff`  output  WIDTH  result `a - b` modulo 2^WIDTH.
- `borrow_out`  output  1  final borrow; 1 iff `a < b` unsigned.
- `ovf`  output  1  signed overflow; present only with `SERSUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On `start=1`: latch `a`, `b` into internal shift registers.
  - Clear the bit counter and the internal borrow.
  - Go to SHIFT.
  - `start=0`: stay in IDLE.
- SHIFT:
  - Each cycle, the cell takes `a_sr[0]`, `b_sr[0]` and the borrow, and produces `d` and `bo`.
  - `d` is shifted into the MSB of the internal result register, which shifts right.
  - `a_sr` and `b_sr` shift right, and the borrow register takes `bo`.
  - The counter increments. After the WIDTH-th bit (counter = WIDTH-1), go to DONE.
- DONE:
  - Entry edge: `diff` ← internal result, `borrow_out` ← final borrow, `ovf` updated.
  - `done=1` for exactly this one cycle.
  - Next state is unconditionally IDLE.
- Cell equations: `d = x ^ y ^ bin`; `bo = (~x & y) | (~(x ^ y) & bin)`.
- `ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1])`, using the latched operands.
- `start` in SHIFT or DONE is ignored; it is neither queued nor able to corrupt the operands.
- `a == b` gives `diff = 0` and `borrow_out = 0`.

## Timing
- Reset state (after the `rst` edge): state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `ovf=0`, counter and all internal registers 0.
- `rst` has priority over every other input in every state. Asserting it mid-SHIFT aborts the operation with no `done`.
- Edge numbering, with `start` sampled at edge k:
  - SHIFT occupies cycles k+1 … k+WIDTH (the boundaries are edges k and k+WIDTH).
  - `busy=1` during those WIDTH cycles.
  - The DONE state is entered at edge k+WIDTH. `done` is high from edge k+WIDTH to edge k+WIDTH+1.
  - Latency from the start edge to `done` high is WIDTH edges.
  - The earliest next `start` is sampled at edge k+WIDTH+2 (the first IDLE cycle).
- Throughput: one operation per WIDTH+2 cycles with `start` held high.
- `diff`, `borrow_out` and `ovf` change only at DONE entry or on reset. They hold between operations.
- `busy` and `done` are registered and never high together.

## Configuration
- `SERSUB_OVF_EN` defined: the `ovf` port exists and is computed as above.
- Undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `serial_subtractor_pkg`:
  - state enum typedef (IDLE, SHIFT, DONE);
  - `SERSUB_DEFAULT_WIDTH = 8`;
  - counter-width helper `$clog2(WIDTH)`.
- Sub-module `full_subtractor`: combinational, ports `x`, `y`, `bin`, `d`, `bo`. One instance, driven from the shift-register LSBs.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Basic subtraction: `a=8'h05`, `b=8'h03`, start at edge k → `done` at edge k+8, `diff=8'h02`, `borrow_out=0`, `busy` high for exactly 8 cycles.
- Borrow case: `a=8'h03`, `b=8'h05` → `diff=8'hFE`, `borrow_out=1`. With `a=8'h00`, `b=8'hFF` → `diff=8'h01`, `borrow_out=1`.
- Signed overflow (macro on): `a=8'h80`, `b=8'h01` → `diff=8'h7F`, `borrow_out=0`, `ovf=1`. Then `a=8'h7F`, `b=8'h01` → `diff=8'h7E`, `ovf=0`.
- Start handling: `start` held high continuously with operands changed mid-SHIFT → the first result uses the original operands. The second start is accepted only at the first IDLE cycle; `done` pulses are spaced 10 cycles apart.
- Reset mid-operation: `rst=1` for one cycle during SHIFT cycle 4 → next cycle IDLE, `busy=0`, `done` never pulses, `diff=0`, `borrow_out=0`.
- Exhaustive check at WIDTH=2 (and WIDTH=4): all `a`,`b` pairs → `diff` and `borrow_out` match the model `{borrow_out,diff} = {1'b0,a} - {1'b0,b}`.
